// File: rtl/bullet_r_ctrl.sv
// Right-turret projectile controller: latches turret motion/muzzle on a fire press, steps the bullet once per frame.
// Optional post-flight cooldown state enabled by defining BULLET_R_COOLDOWN_EN.
module bullet_r_ctrl #(
  parameter logic [7:0] FIRE_KEY        = 8'h28,
  parameter int         SPEED_SHIFT     = 1,
  parameter int         X_MAX           = 639,
  parameter int         Y_MAX           = 479,
  parameter int         COOLDOWN_FRAMES = 15
) (
  input  logic       clk2,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] b_override_motion_x_r,
  input  logic [9:0] b_override_motion_y_r,
  input  logic [9:0] initial_b_r_pos_x,
  input  logic [9:0] initial_b_r_pos_y,
  input  logic       hit_i,
  output logic [9:0] bullet_r_x,
  output logic [9:0] bullet_r_y,
  output logic       bullet_r_active,
  output logic [7:0] shot_count,
  output logic       ready
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLIGHT   = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        fire_prev_q, fire_prev_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [9:0]  dx_q, dx_d, dy_q, dy_d;
  logic [7:0]  shot_q, shot_d;
  logic        active_q, active_d;
  logic        ready_q, ready_d;
`ifdef BULLET_R_COOLDOWN_EN
  logic [4:0]  cnt_q, cnt_d;
`endif

  logic               key_hit, fire_pulse, oob;
  logic signed [11:0] step_x, step_y, nx, ny;

  assign key_hit    = (keycode == FIRE_KEY);
  assign fire_pulse = key_hit && !fire_prev_q;

  // Positions are always in range, so zero-extending them into 12 bits is safe.
  assign step_x = $signed({{2{dx_q[9]}}, dx_q}) <<< SPEED_SHIFT;
  assign step_y = $signed({{2{dy_q[9]}}, dy_q}) <<< SPEED_SHIFT;
  assign nx     = $signed({2'b00, x_q}) + step_x;
  assign ny     = $signed({2'b00, y_q}) + step_y;
  assign oob    = nx[11] || (nx > $signed(12'(X_MAX))) ||
                  ny[11] || (ny > $signed(12'(Y_MAX)));

  always_comb begin
    state_d     = state_q;
    fire_prev_d = key_hit;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    shot_d      = shot_q;
`ifdef BULLET_R_COOLDOWN_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (fire_pulse) begin
          dx_d    = b_override_motion_x_r;
          dy_d    = b_override_motion_y_r;
          x_d     = initial_b_r_pos_x;
          y_d     = initial_b_r_pos_y;
          shot_d  = (shot_q == 8'hFF) ? shot_q : shot_q + 8'd1;
          state_d = S_FLIGHT;
        end
      end
      S_FLIGHT: begin
        // A hit wins over bounds; either way the position keeps its pre-step value.
        if (hit_i || oob) begin
`ifdef BULLET_R_COOLDOWN_EN
          state_d = S_COOLDOWN;
          cnt_d   = 5'(COOLDOWN_FRAMES - 1);
`else
          state_d = S_IDLE;
`endif
        end else begin
          x_d = nx[9:0];
          y_d = ny[9:0];
        end
      end
`ifdef BULLET_R_COOLDOWN_EN
      S_COOLDOWN: begin
        if (cnt_q == 5'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 5'd1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    active_d = (state_d == S_FLIGHT);
    ready_d  = (state_d == S_IDLE);
  end

  // fire_prev resets high so a key held through reset release does not fire.
  always_ff @(posedge clk2) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      fire_prev_q <= 1'b1;
      x_q         <= '0;
      y_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      shot_q      <= '0;
      active_q    <= 1'b0;
      ready_q     <= 1'b1;
`ifdef BULLET_R_COOLDOWN_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fire_prev_q <= fire_prev_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      shot_q      <= shot_d;
      active_q    <= active_d;
      ready_q     <= ready_d;
`ifdef BULLET_R_COOLDOWN_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bullet_r_x      = x_q;
  assign bullet_r_y      = y_q;
  assign bullet_r_active = active_q;
  assign shot_count      = shot_q;
  assign ready           = ready_q;

endmodule

// File: tb/tb_bullet_r_ctrl.sv
// Directed bench for bullet_r_ctrl; cooldown checks compile in when BULLET_R_COOLDOWN_EN is defined.
module tb_bullet_r_ctrl;
  localparam logic [7:0] FIRE = 8'h28;

  logic       clk2 = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic [9:0] mx, my, px, py;
  logic       hit_i;
  logic [9:0] bullet_r_x, bullet_r_y;
  logic       bullet_r_active;
  logic [7:0] shot_count;
  logic       ready;

  int total = 0;
  int bad   = 0;

  always #5 clk2 = ~clk2;

  bullet_r_ctrl dut (
    .clk2(clk2), .Reset(Reset), .keycode(keycode),
    .b_override_motion_x_r(mx), .b_override_motion_y_r(my),
    .initial_b_r_pos_x(px), .initial_b_r_pos_y(py), .hit_i(hit_i),
    .bullet_r_x(bullet_r_x), .bullet_r_y(bullet_r_y),
    .bullet_r_active(bullet_r_active), .shot_count(shot_count), .ready(ready)
  );

  task automatic tick;
    @(posedge clk2);
    #1;
  endtask

  task automatic do_reset;
    Reset = 1'b0; keycode = 8'h00; hit_i = 1'b0;
    mx = '0; my = '0; px = '0; py = '0;
    tick;
    Reset = 1'b1;
    tick;
  endtask

  task automatic press(input logic [9:0] vx, input logic [9:0] vy,
                       input logic [9:0] ix, input logic [9:0] iy);
    mx = vx; my = vy; px = ix; py = iy;
    keycode = FIRE;
    tick;
    keycode = 8'h00;
  endtask

  task automatic end_by_hit;
    hit_i = 1'b1;
    tick;
    hit_i = 1'b0;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin tick; n++; end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL wait_ready timeout ready=%b", ready); end
  endtask

  task automatic test_reset;
    Reset = 1'b0; keycode = FIRE; hit_i = 1'b0;
    mx = 10'd1; my = 10'd1; px = 10'd100; py = 10'd100;
    tick;
    total++;
    if ({bullet_r_x, bullet_r_y, bullet_r_active, shot_count, ready} !== {10'd0, 10'd0, 1'b0, 8'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_vals got x=%0d y=%0d act=%b shots=%0d rdy=%b want 0 0 0 0 1",
               bullet_r_x, bullet_r_y, bullet_r_active, shot_count, ready);
    end
    Reset = 1'b1;
    tick;
    total++;
    if (bullet_r_active !== 1'b0 || shot_count !== 8'd0) begin
      bad++;
      $display("FAIL held_through_reset act=%b shots=%0d want 0 0", bullet_r_active, shot_count);
    end
    keycode = 8'h00;
    tick;
  endtask

  task automatic test_top_edge;
    int errs = 0;
    do_reset;
    press(10'd0, 10'h3FF, 10'd558, 10'd422);
    total++;
    if (bullet_r_x !== 10'd558 || bullet_r_y !== 10'd422 || bullet_r_active !== 1'b1 || shot_count !== 8'd1) begin
      bad++;
      $display("FAIL top_fire got (%0d,%0d) act=%b shots=%0d want (558,422) 1 1",
               bullet_r_x, bullet_r_y, bullet_r_active, shot_count);
    end
    for (int i = 1; i <= 211; i++) begin
      tick;
      if (errs == 0 && (bullet_r_x !== 10'd558 || bullet_r_y !== 10'(422 - 2*i) || bullet_r_active !== 1'b1)) begin
        errs++;
        $display("FAIL top_step%0d got (%0d,%0d) act=%b want (558,%0d) 1",
                 i, bullet_r_x, bullet_r_y, bullet_r_active, 422 - 2*i);
      end
    end
    total++;
    if (errs != 0) bad++;
    tick;
    total++;
    if (bullet_r_active !== 1'b0 || bullet_r_y !== 10'd0 || bullet_r_x !== 10'd558) begin
      bad++;
      $display("FAIL top_end got (%0d,%0d) act=%b want (558,0) 0", bullet_r_x, bullet_r_y, bullet_r_active);
    end
  endtask

  task automatic test_key_held;
    do_reset;
    mx = 10'd1; my = 10'd0; px = 10'd630; py = 10'd50;
    keycode = FIRE;
    tick;
    total++;
    if (bullet_r_active !== 1'b1 || bullet_r_x !== 10'd630) begin
      bad++;
      $display("FAIL held_fire act=%b x=%0d want 1 630", bullet_r_active, bullet_r_x);
    end
    for (int i = 1; i < 50; i++) tick;
    total++;
    if (shot_count !== 8'd1 || bullet_r_active !== 1'b0 || bullet_r_x !== 10'd638) begin
      bad++;
      $display("FAIL held_once shots=%0d act=%b x=%0d want 1 0 638", shot_count, bullet_r_active, bullet_r_x);
    end
    keycode = 8'h00;
    tick;
    press(10'd1, 10'd0, 10'd630, 10'd50);
    total++;
    if (shot_count !== 8'd2 || bullet_r_active !== 1'b1 || bullet_r_x !== 10'd630) begin
      bad++;
      $display("FAIL held_repress shots=%0d act=%b x=%0d want 2 1 630", shot_count, bullet_r_active, bullet_r_x);
    end
    end_by_hit;
  endtask

  task automatic test_dir_latch;
    int errs = 0;
    do_reset;
    press(10'h3FF, 10'd0, 10'd300, 10'd200);
    mx = 10'd1; my = 10'd1;
    for (int i = 1; i <= 5; i++) begin
      tick;
      if (errs == 0 && (bullet_r_x !== 10'(300 - 2*i) || bullet_r_y !== 10'd200)) begin
        errs++;
        $display("FAIL latch_step%0d got (%0d,%0d) want (%0d,200)", i, bullet_r_x, bullet_r_y, 300 - 2*i);
      end
    end
    total++;
    if (errs != 0) bad++;
    end_by_hit;
  endtask

  task automatic test_hit_priority;
    do_reset;
    press(10'd1, 10'd0, 10'd638, 10'd100);
    hit_i = 1'b1;
    tick;
    hit_i = 1'b0;
    total++;
    if (bullet_r_active !== 1'b0 || bullet_r_x !== 10'd638 || bullet_r_y !== 10'd100 || shot_count !== 8'd1) begin
      bad++;
      $display("FAIL hit_oob got (%0d,%0d) act=%b shots=%0d want (638,100) 0 1",
               bullet_r_x, bullet_r_y, bullet_r_active, shot_count);
    end
`ifndef BULLET_R_COOLDOWN_EN
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL ready_after_end got %b want 1", ready); end
    press(10'd1, 10'd1, 10'd10, 10'd10);
    total++;
    if (bullet_r_active !== 1'b1 || shot_count !== 8'd2) begin
      bad++;
      $display("FAIL refire_after_end act=%b shots=%0d want 1 2", bullet_r_active, shot_count);
    end
    end_by_hit;
`endif
    do_reset;
    press(10'd1, 10'd1, 10'd10, 10'd10);
    tick;
    total++;
    if (bullet_r_x !== 10'd12 || bullet_r_y !== 10'd12) begin
      bad++;
      $display("FAIL diag_step got (%0d,%0d) want (12,12)", bullet_r_x, bullet_r_y);
    end
    end_by_hit;
    total++;
    if (bullet_r_active !== 1'b0 || bullet_r_x !== 10'd12 || bullet_r_y !== 10'd12) begin
      bad++;
      $display("FAIL hit_hold got (%0d,%0d) act=%b want (12,12) 0", bullet_r_x, bullet_r_y, bullet_r_active);
    end
  endtask

  task automatic test_zero_motion;
    do_reset;
    press(10'd0, 10'd0, 10'd320, 10'd240);
    for (int i = 0; i < 30; i++) tick;
    total++;
    if (bullet_r_active !== 1'b1 || bullet_r_x !== 10'd320 || bullet_r_y !== 10'd240) begin
      bad++;
      $display("FAIL zero_motion got (%0d,%0d) act=%b want (320,240) 1", bullet_r_x, bullet_r_y, bullet_r_active);
    end
    end_by_hit;
  endtask

`ifdef BULLET_R_COOLDOWN_EN
  task automatic test_cooldown;
    int errs = 0;
    do_reset;
    press(10'd0, 10'd0, 10'd5, 10'd5);
    end_by_hit;
    for (int i = 1; i <= 15; i++) begin
      if (errs == 0 && (ready !== 1'b0 || bullet_r_active !== 1'b0)) begin
        errs++;
        $display("FAIL cool_frame%0d rdy=%b act=%b want 0 0", i, ready, bullet_r_active);
      end
      if (i == 10) keycode = FIRE;
      if (i == 11) keycode = 8'h00;
      tick;
    end
    total++;
    if (errs != 0) bad++;
    total++;
    if (ready !== 1'b1 || shot_count !== 8'd1 || bullet_r_active !== 1'b0) begin
      bad++;
      $display("FAIL cool_done rdy=%b shots=%0d act=%b want 1 1 0", ready, shot_count, bullet_r_active);
    end
    press(10'd0, 10'd0, 10'd5, 10'd5);
    total++;
    if (bullet_r_active !== 1'b1 || shot_count !== 8'd2) begin
      bad++;
      $display("FAIL cool_refire act=%b shots=%0d want 1 2", bullet_r_active, shot_count);
    end
    end_by_hit;
  endtask
`endif

  task automatic test_midflight_reset;
    do_reset;
    press(10'd1, 10'd0, 10'd100, 10'd100);
    tick; tick; tick;
    Reset = 1'b0;
    tick;
    total++;
    if ({bullet_r_x, bullet_r_y, bullet_r_active, shot_count, ready} !== {10'd0, 10'd0, 1'b0, 8'd0, 1'b1}) begin
      bad++;
      $display("FAIL midflight_reset got (%0d,%0d) act=%b shots=%0d rdy=%b want (0,0) 0 0 1",
               bullet_r_x, bullet_r_y, bullet_r_active, shot_count, ready);
    end
    Reset = 1'b1;
    tick;
  endtask

  task automatic test_saturation;
    do_reset;
    for (int i = 0; i < 256; i++) begin
      wait_ready;
      press(10'd0, 10'd0, 10'd1, 10'd1);
      end_by_hit;
    end
    total++;
    if (shot_count !== 8'd255) begin bad++; $display("FAIL shot_sat got %0d want 255", shot_count); end
  endtask

  initial begin
    test_reset;
    test_top_edge;
    test_key_held;
    test_dir_latch;
    test_hit_priority;
    test_zero_motion;
`ifdef BULLET_R_COOLDOWN_EN
    test_cooldown;
`endif
    test_midflight_reset;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bullet_r_ctrl.md
# bullet_r_ctrl

Right-turret projectile controller, directly downstream of the right-turret angle state machine. On a fire key press, it latches the turret's current per-frame motion vector and muzzle position. It then advances one bullet per clk2 edge until the bullet leaves the 640x480 playfield or the collision logic reports a hit. Its position and active flag feed the sprite/colour mapper and the collision detector.

## Interface
Parameters:
- FIRE_KEY, 8'h28: keycode that fires (Enter).
- SPEED_SHIFT, 1: motion vector left-shifted by this amount per frame (step = motion << SPEED_SHIFT).
- X_MAX, 639: last visible column.
- Y_MAX, 479: last visible row.
- COOLDOWN_FRAMES, 15: frames spent in COOLDOWN after a bullet ends (only with BULLET_R_COOLDOWN_EN).

Ports:
- clk2  in  1: clock, one rising edge per frame.
- Reset  in  1: Reset, synchronous, active-low; clock clk2.
- keycode  in  8: current keyboard keycode.
- b_override_motion_x_r  in  10: turret X step, two's complement (10'h3FF = -1).
- b_override_motion_y_r  in  10: turret Y step, two's complement.
- initial_b_r_pos_x  in  10: muzzle X.
- initial_b_r_pos_y  in  10: muzzle Y.
- hit_i  in  1: collision detector reports that the bullet struck a target this frame.
- bullet_r_x  out  10: bullet X.
- bullet_r_y  out  10: bullet Y.
- bullet_r_active  out  1: bullet is drawn and collidable.
- shot_count  out  8: shots fired, saturates at 255.
- ready  out  1: high when in IDLE and able to accept a fire.

## Operation
- States: IDLE, FLIGHT, COOLDOWN.
- Fire detection:
  - fire_prev <= (keycode == FIRE_KEY) on every edge.
  - fire_pulse = (keycode == FIRE_KEY) && !fire_prev.
  - Holding the key fires only once per press.
- IDLE:
  - ready = 1, active = 0.
  - On fire_pulse: latch dx/dy from the motion inputs, load the position from initial_b_r_pos_x/y, increment shot_count (saturating), go to FLIGHT.
- FLIGHT:
  - Priority: hit_i first, then bounds, else move.
  - hit_i = 1: go to END.
  - Otherwise compute nx = x + sext11(dx) <<< SPEED_SHIFT and ny the same way, in 12-bit signed arithmetic.
  - If nx < 0, nx > X_MAX, ny < 0 or ny > Y_MAX: go to END and leave the position unchanged.
  - Else: x <= nx[9:0], y <= ny[9:0].
- END: means COOLDOWN when the macro is defined, IDLE when it is not.
- Direction is frozen at fire time. Turret motion inputs changing during FLIGHT have no effect.
- fire_pulse during FLIGHT or COOLDOWN is ignored and not queued.
- COOLDOWN:
  - active = 0, ready = 0.
  - 5-bit down-counter loaded with COOLDOWN_FRAMES-1 on entry.
  - Go to IDLE when it reads 0.
- Position registers hold their last value outside FLIGHT.
- A zero motion vector stays in FLIGHT indefinitely until hit_i arrives.

## Timing
- All registers update on posedge clk2. Outputs are registered.
- Reset values: state IDLE, bullet_r_x 0, bullet_r_y 0, bullet_r_active 0, shot_count 0, ready 1, fire_prev 1.
  - fire_prev = 1 means a key held through reset release does not fire.
- Fire latency:
  - fire_pulse seen at edge n gives active = 1 and position = muzzle after edge n.
  - The first step is applied at edge n+1.
- Termination:
  - A hit or out-of-bounds condition evaluated at edge k gives active = 0 after edge k.
  - hit_i and out-of-bounds in the same frame count as one termination.
- Cooldown: IDLE (ready = 1) is reached exactly COOLDOWN_FRAMES edges after termination.
- Reset asserted mid-FLIGHT or mid-COOLDOWN returns to the reset values on that edge. Reset overrides fire.

## Configuration
- BULLET_R_COOLDOWN_EN:
  - Defined: COOLDOWN state and counter are present. Termination goes FLIGHT -> COOLDOWN -> IDLE.
  - Undefined: no counter. Termination goes FLIGHT -> IDLE, so ready is 1 on the frame right after active falls.

## Test plan
- Out-of-bounds at top edge: reset, motion (0, 3FF), muzzle (558, 422), FIRE_KEY for one frame.
  - Position (558, 422) with active = 1 after the fire edge.
  - Y falls by 2 per frame.
  - active drops on the frame when y would go below 0: last y = 0, 211 moves.
- Key held: hold FIRE_KEY for 50 frames.
  - shot_count = 1.
  - No refire after termination until the key is released and pressed again.
- Direction latch: fire with motion (3FF, 0), then change the inputs to (1, 1) mid-flight.
  - x keeps decreasing by 2 per frame, y is unchanged.
- Hit priority: assert hit_i together with an out-of-bounds step.
  - Single termination; the position holds the pre-step value.
- Cooldown: with BULLET_R_COOLDOWN_EN and COOLDOWN_FRAMES = 15, after termination:
  - ready = 0 for 15 frames.
  - A fire in frame 10 is ignored.
  - A fire in frame 16 is accepted.
- Mid-flight reset: pull Reset low during FLIGHT.
  - The next edge gives active 0, position (0, 0), shot_count 0, ready 1.
